branch_predictor_gshare: RTL and testbench

Parametrised gshare branch predictor for the fetch stage, the next generation of the per-address global-history predictor. A global history register (GHR) is XOR-folded with the low PC bits to index a pattern history table (PHT) of saturating counters. The prediction port is registered, and the update port is driven from execute/writeback. The block also keeps saturating branch and mispredict statistics. Optionally the GHR is updated speculatively at predict time, with restore on mispredict.

---
 rtl/branch_predictor_gshare.sv | 141 ++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: GHR xor PC indexes a table of saturating counters.
// Define BP_SPEC_HISTORY_EN for speculative GHR update with restore on mispredict.
module branch_predictor_gshare #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned HIST_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_addr,
  output logic                  pred_out_valid,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_index,
  output logic [HIST_WIDTH-1:0] pred_hist,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_index,
  input  logic [HIST_WIDTH-1:0] upd_hist,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic                  stat_clr,
  output logic [HIST_WIDTH-1:0] ghr,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int Entries = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntInit = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
  localparam logic [STAT_WIDTH-1:0] StatMax = '1;

  logic [CNT_WIDTH-1:0]  pht_q [Entries];
  logic [CNT_WIDTH-1:0]  upd_cnt_d;
  logic [ADDR_WIDTH-1:0] pred_idx;
  logic                  pred_dir;
  logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

  logic                  pred_out_valid_q;
  logic                  pred_taken_q;
  logic [ADDR_WIDTH-1:0] pred_index_q;
  logic [HIST_WIDTH-1:0] pred_hist_q;

  logic [STAT_WIDTH-1:0] br_q, br_d, mp_q, mp_d;

  // Reads the pre-update table, so a same-cycle update to this entry is not seen.
  assign pred_idx = pred_addr ^ ADDR_WIDTH'(ghr_q);
  assign pred_dir = pht_q[pred_idx][CNT_WIDTH-1];

  always_comb begin
    upd_cnt_d = pht_q[upd_index];
    if (upd_taken) begin
      if (upd_cnt_d != CntMax) upd_cnt_d = upd_cnt_d + CNT_WIDTH'(1);
    end else if (upd_cnt_d != '0) begin
      upd_cnt_d = upd_cnt_d - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) pht_q[i] <= CntInit;
    end else if (upd_valid) begin
      pht_q[upd_index] <= upd_cnt_d;
    end
  end

`ifdef BP_SPEC_HISTORY_EN
  always_comb begin
    ghr_d = ghr_q;
    // Restore from the carried history wins over this cycle's speculative shift.
    if (upd_valid && upd_mispredict) begin
      ghr_d = {upd_hist[HIST_WIDTH-2:0], upd_taken};
    end else if (pred_valid) begin
      ghr_d = {ghr_q[HIST_WIDTH-2:0], pred_dir};
    end
  end
`else
  logic unused_upd_hist;
  assign unused_upd_hist = ^upd_hist;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[HIST_WIDTH-2:0], upd_taken};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_index_q     <= '0;
      pred_hist_q      <= '0;
    end else begin
      pred_out_valid_q <= pred_valid;
      if (pred_valid) begin
        pred_taken_q <= pred_dir;
        pred_index_q <= pred_idx;
        pred_hist_q  <= ghr_q;
      end
    end
  end

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (stat_clr) begin
      br_d = '0;
      mp_d = '0;
    end else if (upd_valid) begin
      if (br_q != StatMax) br_d = br_q + STAT_WIDTH'(1);
      if (upd_mispredict && mp_q != StatMax) mp_d = mp_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign pred_out_valid   = pred_out_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_index       = pred_index_q;
  assign pred_hist        = pred_hist_q;
  assign ghr              = ghr_q;
  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed, table-driven bench for branch_predictor_gshare (A=8, H=4, C=2, S=16).
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_valid, upd_valid, upd_taken, upd_mispredict, stat_clr;
  logic [7:0]  pred_addr, upd_index;
  logic [3:0]  upd_hist;
  logic        pred_out_valid, pred_taken;
  logic [7:0]  pred_index;
  logic [3:0]  pred_hist, ghr;
  logic [15:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .ADDR_WIDTH(8), .HIST_WIDTH(4), .CNT_WIDTH(2), .STAT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_addr(pred_addr),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_index(pred_index), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .stat_clr(stat_clr), .ghr(ghr),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        pv;
    logic [7:0]  pa;
    logic        uv;
    logic [7:0]  ui;
    logic [3:0]  uh;
    logic        ut;
    logic        um;
    logic        clr;
    logic [49:0] exp;  // {pov, pt, pidx, phist, ghr, branches, mispredicts}
  } vec_t;

  function automatic vec_t mk(input logic pv, input logic [7:0] pa, input logic uv,
                              input logic [7:0] ui, input logic ut, input logic um,
                              input logic clr, input logic e_pov, input logic e_pt,
                              input logic [7:0] e_pi, input logic [3:0] e_ph,
                              input logic [3:0] e_g, input logic [15:0] e_sb,
                              input logic [15:0] e_sm);
    vec_t v;
    v.pv = pv; v.pa = pa; v.uv = uv; v.ui = ui; v.uh = 4'h0;
    v.ut = ut; v.um = um; v.clr = clr;
    v.exp = {e_pov, e_pt, e_pi, e_ph, e_g, e_sb, e_sm};
    return v;
  endfunction

  function automatic logic [49:0] outs();
    return {pred_out_valid, pred_taken, pred_index, pred_hist, ghr,
            stat_branches, stat_mispredicts};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pa, input logic uv,
                       input logic [7:0] ui, input logic [3:0] uh, input logic ut,
                       input logic um, input logic clr);
    pred_valid = pv; pred_addr = pa; upd_valid = uv; upd_index = ui;
    upd_hist = uh; upd_taken = ut; upd_mispredict = um; stat_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0);
    #7;
    step();
    rst_n = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    drive(0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0);
    vecs[0] = mk(1, 8'h10, 0, 8'h00, 0, 0, 0, 1, 0, 8'h10, 4'h0, 4'h0, 16'd0, 16'd0);
    vecs[1] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h10, 4'h0, 4'h0, 16'd0, 16'd0);
    vecs[2] = mk(0, 8'h00, 1, 8'h10, 1, 0, 0, 0, 0, 8'h10, 4'h0, 4'h1, 16'd1, 16'd0);
    vecs[3] = mk(0, 8'h00, 1, 8'h10, 1, 0, 0, 0, 0, 8'h10, 4'h0, 4'h3, 16'd2, 16'd0);
    vecs[4] = mk(1, 8'h13, 0, 8'h00, 0, 0, 0, 1, 1, 8'h10, 4'h3, 4'h3, 16'd2, 16'd0);
    vecs[5] = mk(0, 8'h00, 1, 8'h20, 0, 1, 0, 0, 1, 8'h10, 4'h3, 4'h6, 16'd3, 16'd1);
    vecs[6] = mk(0, 8'h00, 1, 8'h10, 0, 0, 1, 0, 1, 8'h10, 4'h3, 4'hC, 16'd0, 16'd0);
    vecs[7] = mk(1, 8'h1C, 0, 8'h00, 0, 0, 0, 1, 1, 8'h10, 4'hC, 4'hC, 16'd0, 16'd0);

    do_reset();
    check("reset_state", 64'(outs()), 64'h0);

`ifndef BP_SPEC_HISTORY_EN
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].uv, vecs[i].ui, vecs[i].uh,
            vecs[i].ut, vecs[i].um, vecs[i].clr);
      step();
      check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
    end

    // Saturation at index 0x20; pred_addr chosen so that addr ^ ghr == 0x20.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1, 8'h20, 4'h0, 1, 0, 0);
      step();
    end
    drive(1, 8'h2F, 0, 8'h00, 4'h0, 0, 0, 0);
    step();
    check("sat_high", 64'({pred_out_valid, pred_taken, pred_index, pred_hist}),
          64'({1'b1, 1'b1, 8'h20, 4'hF}));
    drive(0, 8'h00, 1, 8'h20, 4'h0, 0, 0, 0);
    step();
    drive(1, 8'h2E, 0, 8'h00, 4'h0, 0, 0, 0);
    step();
    check("sat_dec1", 64'({pred_taken, pred_index, pred_hist}), 64'({1'b1, 8'h20, 4'hE}));
    for (int i = 0; i < 2; i++) begin
      drive(0, 8'h00, 1, 8'h20, 4'h0, 0, 0, 0);
      step();
    end
    drive(1, 8'h28, 0, 8'h00, 4'h0, 0, 0, 0);
    step();
    check("sat_dec3", 64'({pred_taken, pred_index}), 64'({1'b0, 8'h20}));
    drive(0, 8'h00, 1, 8'h20, 4'h0, 0, 0, 0);
    step();
    drive(1, 8'h20, 0, 8'h00, 4'h0, 0, 0, 0);
    step();
    check("sat_low", 64'({pred_taken, pred_index, ghr}), 64'({1'b0, 8'h20, 4'h0}));
`else
    // Restore wins over a same-cycle speculative shift.
    drive(1, 8'h00, 1, 8'h40, 4'h5, 1, 1, 0);
    step();
    check("spec_restore", 64'({pred_out_valid, pred_hist, ghr}), 64'({1'b1, 4'h0, 4'hB}));
    drive(0, 8'h00, 1, 8'h40, 4'h0, 0, 0, 0);
    step();
    check("spec_correct_upd", 64'(ghr), 64'(4'hB));
    drive(1, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0);
    step();
    check("spec_pred", 64'({pred_taken, pred_index, pred_hist}), 64'({1'b0, 8'h0B, 4'hB}));
    check("spec_shift", 64'(ghr), 64'(4'h6));
`endif

    // Same-cycle predict and update on entry 0x10 (counter at 01, ghr 0).
    do_reset();
    drive(1, 8'h10, 1, 8'h10, 4'h0, 1, 0, 0);
    step();
    check("same_cycle_old", 64'({pred_out_valid, pred_taken, pred_index}),
          64'({1'b1, 1'b0, 8'h10}));
`ifdef BP_SPEC_HISTORY_EN
    drive(1, 8'h10, 0, 8'h00, 4'h0, 0, 0, 0);
`else
    drive(1, 8'h11, 0, 8'h00, 4'h0, 0, 0, 0);
`endif
    step();
    check("same_cycle_next", 64'({pred_out_valid, pred_taken, pred_index}),
          64'({1'b1, 1'b1, 8'h10}));

    // Asynchronous reset between clock edges clears outputs at once.
    drive(0, 8'h00, 0, 8'h00, 4'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'(outs()), 64'h0);

    // Statistics.
    do_reset();
    drive(0, 8'h00, 1, 8'h40, 4'h0, 1, 0, 0); step();
    drive(0, 8'h00, 1, 8'h41, 4'h0, 0, 1, 0); step();
    drive(0, 8'h00, 1, 8'h42, 4'h0, 1, 0, 0); step();
    check("stat_count", 64'({stat_branches, stat_mispredicts}), 64'({16'd3, 16'd1}));
    drive(0, 8'h00, 1, 8'h40, 4'h0, 1, 1, 1);
    step();
    check("stat_clr_prio", 64'({stat_branches, stat_mispredicts}), 64'h0);
    for (int i = 0; i < 65534; i++) begin
      drive(0, 8'h00, 1, 8'h40, 4'h0, 1, 1, 0);
      step();
    end
    check("stat_near_max", 64'({stat_branches, stat_mispredicts}),
          64'({16'hFFFE, 16'hFFFE}));
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 8'h40, 4'h0, 1, 1, 0);
      step();
    end
    check("stat_saturate", 64'({stat_branches, stat_mispredicts}),
          64'({16'hFFFF, 16'hFFFF}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
